// File: rtl/predictor_update_sequencer_if.sv
// Predictor update sequencer bus.
// Groups the three handshakes around the sequencer:
//   prediction push : pred_valid/pred_ready with pred_pc, pred_local,
//                     pred_global, pred_choice
//   resolution      : res_valid/res_ready with res_taken
//   table update    : upd_valid/upd_ready with upd_pc, upd_ghist, upd_taken,
//                     upd_local_ok, upd_global_ok
// plus status outputs ghist (speculative history), count (occupancy) and
// mispredict (one-cycle recovery pulse).
// The slave modport is the sequencer; the master modport is its environment.
interface predictor_update_sequencer_if #(
  parameter int PCW   = 12,
  parameter int GHW   = 12,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic           pred_valid;
  logic [PCW-1:0] pred_pc;
  logic           pred_local;
  logic           pred_global;
  logic           pred_choice;
  logic           pred_ready;
  logic [GHW-1:0] ghist;

  logic           res_valid;
  logic           res_taken;
  logic           res_ready;

  logic           upd_valid;
  logic [PCW-1:0] upd_pc;
  logic [GHW-1:0] upd_ghist;
  logic           upd_taken;
  logic           upd_local_ok;
  logic           upd_global_ok;
  logic           upd_ready;

  logic           mispredict;
  logic [CW-1:0]  count;

  modport slave (
    input  pred_valid, pred_pc, pred_local, pred_global, pred_choice,
    output pred_ready, ghist,
    input  res_valid, res_taken,
    output res_ready,
    output upd_valid, upd_pc, upd_ghist, upd_taken, upd_local_ok, upd_global_ok,
    input  upd_ready,
    output mispredict, count
  );

  modport master (
    output pred_valid, pred_pc, pred_local, pred_global, pred_choice,
    input  pred_ready, ghist,
    output res_valid, res_taken,
    input  res_ready,
    input  upd_valid, upd_pc, upd_ghist, upd_taken, upd_local_ok, upd_global_ok,
    output upd_ready,
    input  mispredict, count
  );
endinterface

// File: rtl/predictor_update_sequencer.sv
// Predictor update sequencer.
// Keeps in-flight predicted branches in a circular FIFO together with the
// speculative global history they were predicted under. When the oldest
// branch resolves, it is popped and one table-update request is issued.
// A wrong final prediction flushes all younger (wrong-path) entries and
// rebuilds the global history from the mispredicted branch's snapshot.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - predictor_update_sequencer_if.slave (push, resolve, update, status)
module predictor_update_sequencer #(
  parameter int PCW   = 12,
  parameter int GHW   = 12,
  parameter int DEPTH = 8
) (
  input logic clock,
  input logic reset,
  predictor_update_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, UPDATE} seqStateT;

  seqStateT       state, stateNext;
  logic [PW-1:0]  rdPtr, wrPtr;
  logic [CW-1:0]  count;
  logic [GHW-1:0] ghist;
  logic           mispredict;

  logic [PCW-1:0] pcMem   [DEPTH];
  logic [GHW-1:0] snapMem [DEPTH];
  logic [DEPTH-1:0] localMem, globalMem, finalMem;

  logic [PCW-1:0] updPc;
  logic [GHW-1:0] updGhist;
  logic           updTaken, updLocalOk, updGlobalOk, updValid;

  logic predFinal, push, pop, flush;

  function automatic logic [GHW-1:0] shiftIn(input logic [GHW-1:0] hist,
                                              input logic bitIn);
    return {hist[GHW-2:0], bitIn};
  endfunction

  assign predFinal = bus.pred_choice ? bus.pred_global : bus.pred_local;
  assign bus.pred_ready = (count < CW'(DEPTH));
  assign bus.res_ready  = (state == IDLE) && (count != '0);
  assign push  = bus.pred_valid && bus.pred_ready;
  assign pop   = bus.res_valid && bus.res_ready;
  assign flush = pop && (finalMem[rdPtr] != bus.res_taken);

  // Entry storage: payload only, no reset needed since count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      pcMem[wrPtr]     <= bus.pred_pc;
      snapMem[wrPtr]   <= ghist;
      localMem[wrPtr]  <= bus.pred_local;
      globalMem[wrPtr] <= bus.pred_global;
      finalMem[wrPtr]  <= predFinal;
    end
  end

  // FIFO control and speculative history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      ghist      <= '0;
      mispredict <= 1'b0;
    end else begin
      mispredict <= flush;
      if (flush) begin
        // A same-cycle push is wrong-path: wrPtr is not advanced, so it is dropped.
        rdPtr <= wrPtr;
        count <= '0;
        ghist <= shiftIn(snapMem[rdPtr], bus.res_taken);
      end else begin
        if (push) begin
          wrPtr <= wrPtr + 1'b1;
          ghist <= shiftIn(ghist, predFinal);
        end
        if (pop) rdPtr <= rdPtr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Update payload, captured at resolution and held through the UPDATE state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      updPc       <= '0;
      updGhist    <= '0;
      updTaken    <= 1'b0;
      updLocalOk  <= 1'b0;
      updGlobalOk <= 1'b0;
    end else if (pop) begin
      updPc       <= pcMem[rdPtr];
      updGhist    <= snapMem[rdPtr];
      updTaken    <= bus.res_taken;
      updLocalOk  <= (localMem[rdPtr] == bus.res_taken);
      updGlobalOk <= (globalMem[rdPtr] == bus.res_taken);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    updValid  = 1'b0;
    case (state)
      IDLE:   if (pop) stateNext = UPDATE;
      UPDATE: begin
        updValid = 1'b1;
        if (bus.upd_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.ghist         = ghist;
  assign bus.count         = count;
  assign bus.mispredict    = mispredict;
  assign bus.upd_valid     = updValid;
  assign bus.upd_pc        = updPc;
  assign bus.upd_ghist     = updGhist;
  assign bus.upd_taken     = updTaken;
  assign bus.upd_local_ok  = updLocalOk;
  assign bus.upd_global_ok = updGlobalOk;
endmodule

// File: tb/tb_predictor_update_sequencer.sv
module tb_predictor_update_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  predictor_update_sequencer_if #(.PCW(12), .GHW(12), .DEPTH(8)) bus ();

  predictor_update_sequencer #(.PCW(12), .GHW(12), .DEPTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int passCnt = 0;
  int failCnt = 0;
  int total   = 0;
  int updCount = 0;
  bit sawBad  = 1'b0;

  // Inputs are stable around the falling edge; a handshake seen here
  // completes at the following rising edge.
  always @(negedge clock) begin
    if (bus.upd_valid && bus.upd_ready) updCount++;
    if (bus.upd_valid && bus.upd_pc == 12'h0AB) sawBad = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [11:0] pc, input logic l, input logic g, input logic c);
    bus.pred_valid = 1'b1;
    bus.pred_pc = pc; bus.pred_local = l; bus.pred_global = g; bus.pred_choice = c;
    tick();
    bus.pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic taken);
    bus.res_valid = 1'b1;
    bus.res_taken = taken;
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic ack();
    bus.upd_ready = 1'b1;
    tick();
    bus.upd_ready = 1'b0;
  endtask

  initial begin
    bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.pred_local = 1'b0;
    bus.pred_global = 1'b0; bus.pred_choice = 1'b0;
    bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.upd_ready = 1'b0;

    tick();
    chk("rst_pred_ready", 32'(bus.pred_ready), 32'd1);
    chk("rst_res_ready",  32'(bus.res_ready),  32'd0);
    chk("rst_count",      32'(bus.count),      32'd0);
    chk("rst_ghist",      32'(bus.ghist),      32'd0);
    chk("rst_upd_valid",  32'(bus.upd_valid),  32'd0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single correct prediction
    push(12'h010, 1'b1, 1'b0, 1'b0);
    chk("t1_count", 32'(bus.count), 32'd1);
    chk("t1_ghist_push", 32'(bus.ghist), 32'h001);
    chk("t1_res_ready", 32'(bus.res_ready), 32'd1);
    resolve(1'b1);
    chk("t1_upd_valid", 32'(bus.upd_valid), 32'd1);
    chk("t1_upd_pc", 32'(bus.upd_pc), 32'h010);
    chk("t1_upd_taken", 32'(bus.upd_taken), 32'd1);
    chk("t1_local_ok", 32'(bus.upd_local_ok), 32'd1);
    chk("t1_global_ok", 32'(bus.upd_global_ok), 32'd0);
    chk("t1_upd_ghist", 32'(bus.upd_ghist), 32'h000);
    chk("t1_mispredict", 32'(bus.mispredict), 32'd0);
    chk("t1_ghist", 32'(bus.ghist), 32'h001);
    chk("t1_res_ready_upd", 32'(bus.res_ready), 32'd0);
    ack();
    chk("t1_upd_done", 32'(bus.upd_valid), 32'd0);
    chk("t1_upd_count", 32'(updCount), 32'd1);

    // Fill to DEPTH, overflow attempt, then drain in order
    for (int i = 0; i < 8; i++) push(12'(12'h100 + i), 1'b1, 1'b0, 1'b0);
    chk("t2_count_full", 32'(bus.count), 32'd8);
    chk("t2_pred_ready_full", 32'(bus.pred_ready), 32'd0);
    chk("t2_ghist_full", 32'(bus.ghist), 32'h1FF);
    push(12'h1FF, 1'b0, 1'b0, 1'b0);
    chk("t2_count_ovf", 32'(bus.count), 32'd8);
    chk("t2_ghist_ovf", 32'(bus.ghist), 32'h1FF);
    resolve(1'b1);
    chk("t2_count_pop", 32'(bus.count), 32'd7);
    chk("t2_pred_ready_pop", 32'(bus.pred_ready), 32'd1);
    chk("t2_upd_pc0", 32'(bus.upd_pc), 32'h100);
    chk("t2_ghist_pop", 32'(bus.ghist), 32'h1FF);
    ack();
    for (int i = 1; i < 8; i++) begin
      resolve(1'b1);
      chk("t2_drain_pc", 32'(bus.upd_pc), 32'(12'h100 + i));
      ack();
    end
    chk("t2_count_empty", 32'(bus.count), 32'd0);
    chk("t2_res_ready_empty", 32'(bus.res_ready), 32'd0);
    chk("t2_upd_count", 32'(updCount), 32'd9);

    // Mispredict flush: A final 1 (via global), B final 0, C final 1
    push(12'h0A0, 1'b0, 1'b1, 1'b1);
    push(12'h0B0, 1'b0, 1'b1, 1'b0);
    push(12'h0C0, 1'b1, 1'b0, 1'b0);
    chk("t3_count", 32'(bus.count), 32'd3);
    chk("t3_ghist", 32'(bus.ghist), 32'hFFD);
    resolve(1'b0);
    chk("t3_mispredict", 32'(bus.mispredict), 32'd1);
    chk("t3_count_flush", 32'(bus.count), 32'd0);
    chk("t3_ghist_restore", 32'(bus.ghist), 32'h3FE);
    chk("t3_upd_pc", 32'(bus.upd_pc), 32'h0A0);
    chk("t3_upd_ghist", 32'(bus.upd_ghist), 32'h1FF);
    chk("t3_upd_taken", 32'(bus.upd_taken), 32'd0);
    chk("t3_local_ok", 32'(bus.upd_local_ok), 32'd1);
    chk("t3_global_ok", 32'(bus.upd_global_ok), 32'd0);
    tick();
    chk("t3_mispredict_pulse", 32'(bus.mispredict), 32'd0);
    chk("t3_upd_valid_held", 32'(bus.upd_valid), 32'd1);
    ack();

    // Backpressure: upd_ready low for 5 cycles while pushes continue
    push(12'h0D0, 1'b1, 1'b0, 1'b0);
    chk("t4_ghist_d", 32'(bus.ghist), 32'h7FD);
    resolve(1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i < 2) push(12'(12'h0E0 + 16 * i), 1'b1, 1'b0, 1'b0);
      else tick();
      chk("t4_upd_valid", 32'(bus.upd_valid), 32'd1);
      chk("t4_upd_pc", 32'(bus.upd_pc), 32'h0D0);
      chk("t4_upd_ghist", 32'(bus.upd_ghist), 32'h3FE);
      chk("t4_res_ready", 32'(bus.res_ready), 32'd0);
    end
    chk("t4_count", 32'(bus.count), 32'd2);
    chk("t4_ghist", 32'(bus.ghist), 32'hFF7);
    ack();
    chk("t4_upd_count", 32'(updCount), 32'd11);

    // Same-cycle push and mispredicting resolve of E
    bus.pred_valid = 1'b1; bus.pred_pc = 12'h0AB;
    bus.pred_local = 1'b1; bus.pred_global = 1'b0; bus.pred_choice = 1'b0;
    resolve(1'b0);
    bus.pred_valid = 1'b0;
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_mispredict", 32'(bus.mispredict), 32'd1);
    chk("t5_ghist", 32'(bus.ghist), 32'hFFA);
    chk("t5_upd_pc", 32'(bus.upd_pc), 32'h0E0);
    ack();
    chk("t5_res_ready", 32'(bus.res_ready), 32'd0);

    // Same-cycle push and correct resolve
    push(12'h011, 1'b1, 1'b0, 1'b0);
    chk("t6_ghist_h", 32'(bus.ghist), 32'hFF5);
    bus.pred_valid = 1'b1; bus.pred_pc = 12'h022;
    bus.pred_local = 1'b0; bus.pred_global = 1'b1; bus.pred_choice = 1'b0;
    resolve(1'b1);
    bus.pred_valid = 1'b0;
    chk("t6_count", 32'(bus.count), 32'd1);
    chk("t6_ghist", 32'(bus.ghist), 32'hFEA);
    chk("t6_upd_pc", 32'(bus.upd_pc), 32'h011);
    chk("t6_mispredict", 32'(bus.mispredict), 32'd0);
    ack();
    chk("t6_no_bad_pc", 32'(sawBad), 32'd0);

    // Asynchronous reset while an update is pending with 3 entries queued
    push(12'h033, 1'b1, 1'b0, 1'b0);
    push(12'h044, 1'b1, 1'b0, 1'b0);
    push(12'h055, 1'b1, 1'b0, 1'b0);
    resolve(1'b0);
    chk("t7_count", 32'(bus.count), 32'd3);
    chk("t7_upd_valid", 32'(bus.upd_valid), 32'd1);
    chk("t7_upd_pc", 32'(bus.upd_pc), 32'h022);
    chk("t7_upd_count_pre", 32'(updCount), 32'd13);
    #1;
    reset = 1'b1;
    bus.upd_ready = 1'b1;
    #1;
    chk("t7_rst_upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("t7_rst_count", 32'(bus.count), 32'd0);
    chk("t7_rst_ghist", 32'(bus.ghist), 32'd0);
    chk("t7_rst_pred_ready", 32'(bus.pred_ready), 32'd1);
    chk("t7_rst_res_ready", 32'(bus.res_ready), 32'd0);
    chk("t7_rst_mispredict", 32'(bus.mispredict), 32'd0);
    chk("t7_rst_upd_pc", 32'(bus.upd_pc), 32'd0);
    chk("t7_rst_upd_ghist", 32'(bus.upd_ghist), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    bus.upd_ready = 1'b0;
    chk("t7_post_upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("t7_post_upd_count", 32'(updCount), 32'd13);
    chk("t7_post_count", 32'(bus.count), 32'd0);

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end
endmodule

// File: doc/predictor_update_sequencer.md
PREDICTOR_UPDATE_SEQUENCER -- requirements
Module: predictor_update_sequencer

Interface
REQ-001 SHALL have parameter PCW, default 12, branch PC width.
REQ-002 SHALL have parameter GHW, default 12, global history width.
REQ-003 SHALL have parameter DEPTH, default 8, in-flight branch entries (power of 2, >=2).
REQ-004 clock  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pred_valid  in  1  new branch predicted this cycle.
REQ-007 pred_pc  in  PCW  PC of predicted branch.
REQ-008 pred_local, pred_global, pred_choice  in  1 each  local bit, global bit, choice bit (1 = use global).
REQ-009 pred_ready  out  1  entry accepted when pred_valid && pred_ready.
REQ-010 ghist  out  GHW  speculative global history, fed to the predictor tables.
REQ-011 res_valid  in  1  oldest in-flight branch resolved.
REQ-012 res_taken  in  1  actual outcome of that branch.
REQ-013 res_ready  out  1  resolution accepted when res_valid && res_ready.
REQ-014 upd_valid  out  1  table-update request.
REQ-015 upd_pc  out  PCW; upd_ghist  out  GHW; upd_taken  out  1  update payload.
REQ-016 upd_local_ok, upd_global_ok  out  1 each  component prediction matched outcome (choice training).
REQ-017 upd_ready  in  1  tables accept the update.
REQ-018 mispredict  out  1  one-cycle recovery pulse.
REQ-019 count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-020 Final prediction SHALL be pred_choice ? pred_global : pred_local.
REQ-021 Entries SHALL be stored in a circular FIFO: {pc, local, global, final, ghist snapshot before shift}; pointers wrap DEPTH-1 -> 0.
REQ-022 pred_ready SHALL be (count < DEPTH); push when full is impossible.
REQ-023 On push, ghist SHALL shift left in the next cycle: ghist <= {ghist[GHW-2:0], final}.
REQ-024 FSM states: IDLE, UPDATE.
REQ-025 res_ready SHALL be (state == IDLE) && (count != 0).
REQ-026 IDLE -> UPDATE on resolution accept: pop head; latch upd_pc = head pc, upd_ghist = head snapshot, upd_taken = res_taken, upd_local_ok = (local == res_taken), upd_global_ok = (global == res_taken).
REQ-027 In UPDATE, upd_valid SHALL be 1 with payload held stable until upd_ready; UPDATE -> IDLE on the edge where upd_valid && upd_ready (single-cycle minimum, no same-cycle return).
REQ-028 If head final != res_taken at resolution accept: in the next cycle mispredict SHALL pulse 1; all remaining entries SHALL be flushed (count = 0, rd = wr); ghist <= {head snapshot[GHW-2:0], res_taken}.
REQ-029 On a correct resolution, ghist SHALL be unchanged by the pop.
REQ-030 Simultaneous push and correct-resolution pop: count unchanged, both pointers advance, ghist shifts per REQ-023.
REQ-031 Simultaneous push and mispredicting pop: pushed entry SHALL be discarded (wrong path); flush and restore of REQ-028 win; count = 0.
REQ-032 Predictions SHALL be accepted in UPDATE state, subject to REQ-022.
REQ-033 count SHALL never exceed DEPTH nor underflow; pop with count 0 impossible per REQ-025.

Reset
REQ-034 reset asserted at any time SHALL immediately clear: state = IDLE, pointers = 0, count = 0, ghist = 0, upd_valid = 0, mispredict = 0, upd payload = 0; pred_ready = 1, res_ready = 0.
REQ-035 Reset mid-UPDATE SHALL drop the pending update without an upd_valid && upd_ready handshake.

Verification
REQ-036 Push PC 0x010, local=1, choice=0; resolve taken -> ghist 0x001; one update: upd_pc 0x010, upd_taken 1, upd_local_ok 1; mispredict 0.
REQ-037 Push 8 entries, DEPTH 8 -> count 8, pred_ready 0; 9th pred_valid ignored; one resolution -> pred_ready 1 after pop.
REQ-038 Push A (final 1) then B, C; resolve A not-taken -> mispredict pulse, count 0, ghist = {A snapshot[10:0], 0}; upd_global_ok/upd_local_ok per entry bits.
REQ-039 Hold upd_ready 0 for 5 cycles in UPDATE -> upd_valid and payload stable, res_ready 0, pushes still accepted.
REQ-040 Same-cycle push and mispredicting resolve -> count 0, pushed PC never appears on upd_pc.
REQ-041 Assert reset while upd_valid 1 and count 3 -> all outputs at REQ-034 values in the same cycle, no update issued.
